// File: rtl/bar_level_encoder_pkg.sv
// Shared widths, FSM state type and the bar-to-level conversion used by the
// bar level encoder.
package bar_level_encoder_pkg;

  localparam int unsigned BAR_W = 7;
  localparam int unsigned LVL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    OFFER   = 2'd2
  } state_t;

  // Returns {illegal, level}; level is the leading-ones run from the MSB,
  // illegal is set when any one appears after that run has ended.
  function automatic logic [LVL_W:0] bar_to_level(input logic [BAR_W-1:0] bar);
    logic [LVL_W-1:0] lvl;
    logic             run;
    logic             bad;
    lvl = '0;
    run = 1'b1;
    bad = 1'b0;
    for (int unsigned i = 0; i < BAR_W; i++) begin
      if (bar[BAR_W-1-i]) begin
        if (run) lvl = lvl + LVL_W'(1);
        else     bad = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return {bad, lvl};
  endfunction

endpackage

// File: rtl/bar_level_encoder_check.sv
// Combinational bar-code encoder and validator.
module bar_code_check
  import bar_level_encoder_pkg::*;
(
  input  logic [BAR_W-1:0] bar,
  output logic [LVL_W-1:0] level,
  output logic             illegal
);

  always_comb begin
    {illegal, level} = bar_to_level(bar);
  end

endmodule

// File: rtl/bar_level_encoder.sv
// Registers a bar code, validates it, debounces the resulting level and
// offers each new stable level on a valid/ready handshake.
module bar_level_encoder
  import bar_level_encoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           input_data,
  input  logic                 sample_en,
  output logic [2:0]           output_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 code_error,
  output logic [ERR_CNT_W-1:0] error_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [BAR_W-1:0] input_q;
  logic             sample_q;
  logic [LVL_W-1:0] level;
  logic             illegal;

  state_t           state, state_n;
  logic [LVL_W-1:0] cand, cand_n;
  logic [LVL_W-1:0] last_level, last_level_n;
  logic [LVL_W-1:0] data_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  bar_code_check u_check (
    .bar     (input_q),
    .level   (level),
    .illegal (illegal)
  );

  // sample_q marks edges on which input_q holds a freshly captured code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      input_q  <= '0;
      sample_q <= 1'b0;
    end else begin
      sample_q <= sample_en;
      if (sample_en) input_q <= input_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_error  <= 1'b0;
      error_count <= '0;
    end else begin
      code_error <= sample_q & illegal;
      if (sample_q && illegal && (error_count != '1))
        error_count <= error_count + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= '0;
      last_level  <= '0;
      cnt         <= '0;
      output_data <= '0;
    end else begin
      state       <= state_n;
      cand        <= cand_n;
      last_level  <= last_level_n;
      cnt         <= cnt_n;
      output_data <= data_n;
    end
  end

  always_comb begin
    state_n      = state;
    cand_n       = cand;
    last_level_n = last_level;
    cnt_n        = cnt;
    data_n       = output_data;
    unique case (state)
      IDLE: begin
        if (sample_q && (level != last_level)) begin
          state_n = QUALIFY;
          cand_n  = level;
          cnt_n   = CNT_W'(1);
        end
      end
      QUALIFY: begin
        if (sample_q) begin
          if (level == cand) begin
            if (cnt == CNT_LAST) begin
              state_n = OFFER;
              data_n  = cand;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end else if (level == last_level) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cand_n = level;
            cnt_n  = CNT_W'(1);
          end
        end
      end
      OFFER: begin
        if (out_ready) begin
          last_level_n = output_data;
          state_n      = IDLE;
          cnt_n        = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_valid = (state == OFFER);

endmodule
